// File: rtl/gpio_mulpop_pkg.sv
// Shared constants for the gpio_mulpop peripheral: register map, FSM encodings,
// STATUS bit positions and the popcount helper.
package gpio_mulpop_pkg;

    localparam logic [15:0] ADDR_A1   = 16'h037F;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_W    = 16'h0390;
    localparam logic [15:0] ADDR_L    = 16'h0398;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;
    localparam logic [15:0] ADDR_HI   = 16'h03A8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_MULT  = 2'd2;
    localparam state_t ST_COUNT = 2'd3;

    localparam int STAT_VALID = 0;
    localparam int STAT_READY = 1;
    localparam int STAT_DONE  = 2;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gpio_mulpop_if.sv
// Emulated system bus seen by gpio_mulpop: level strobes, 16-bit address, 32-bit data.
interface gpio_mulpop_if;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;

    modport master (output saddress, srd, swr, sdata_in, input sdata_out);
    modport slave  (input saddress, srd, swr, sdata_in, output sdata_out);
endinterface

// File: rtl/gpio_mulpop_core.sv
// mulpop_core: LOAD/MULT/COUNT sequencer, shift-add multiplier and result registers.
// Upper-result register exists only with GPIO_MULPOP_RESULT_HI_EN.
module mulpop_core
    import gpio_mulpop_pkg::*;
#(
    parameter int OP_W = 24
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic [OP_W-1:0] a1,
    input  logic [OP_W-1:0] a2,
    input  logic            start,
    output logic            busy,
    output logic            done_pulse,
    output logic [31:0]     res_lo,
`ifdef GPIO_MULPOP_RESULT_HI_EN
    output logic [31:0]     res_hi,
`endif
    output logic [5:0]      ones,
    output logic            valid,
    output logic            ready,
    output logic            done
);
    localparam int RES_W = 2 * OP_W;
    localparam int IDX_W = (OP_W > 1) ? $clog2(OP_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OP_W - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [OP_W-1:0]   a1s_q, a1s_d, a2s_q, a2s_d;
    logic [RES_W-1:0]  acc_q, acc_d, prod_s;
    logic [31:0]       w_q, w_d;
    logic [5:0]        l_q, l_d;
    logic              valid_q, valid_d, ready_q, ready_d, done_q, done_d;
    logic [63:0]       acc_ext_s;

    assign prod_s    = {{OP_W{1'b0}}, a1s_q} << idx_q;
    assign acc_ext_s = 64'(acc_q);

    // Sequencer and datapath next-state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a1s_d   = a1s_q;
        a2s_d   = a2s_q;
        acc_d   = acc_q;
        w_d     = w_q;
        l_d     = l_q;
        valid_d = valid_q;
        ready_d = ready_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
                else       state_d = ST_IDLE;
            end
            ST_LOAD: begin
                a1s_d   = a1;
                a2s_d   = a2;
                acc_d   = '0;
                idx_d   = '0;
                ready_d = 1'b0;
                done_d  = 1'b0;
                state_d = ST_MULT;
            end
            ST_MULT: begin
                if (a2s_q[idx_q]) acc_d = acc_q + prod_s;
                else              acc_d = acc_q;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_COUNT;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_MULT;
                end
            end
            ST_COUNT: begin
                w_d     = acc_ext_s[31:0];
                l_d     = popcount32(acc_ext_s[31:0]);
                valid_d = (acc_ext_s[63:32] == 32'd0);
                ready_d = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a1s_q   <= '0;
            a2s_q   <= '0;
            acc_q   <= '0;
            w_q     <= 32'd0;
            l_q     <= 6'd0;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a1s_q   <= a1s_d;
            a2s_q   <= a2s_d;
            acc_q   <= acc_d;
            w_q     <= w_d;
            l_q     <= l_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

`ifdef GPIO_MULPOP_RESULT_HI_EN
    logic [31:0] hi_q, hi_d;

    always_comb begin
        hi_d = (state_q == ST_COUNT) ? acc_ext_s[63:32] : hi_q;
    end

    // Upper product word, captured alongside W
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) hi_q <= 32'd0;
        else          hi_q <= hi_d;
    end

    assign res_hi = hi_q;
`endif

    assign busy       = (state_q != ST_IDLE);
    assign done_pulse = (state_q == ST_COUNT);
    assign res_lo     = w_q;
    assign ones       = l_q;
    assign valid      = valid_q;
    assign ready      = ready_q;
    assign done       = done_q;

endmodule

// File: rtl/gpio_mulpop.sv
// gpio_mulpop top: bus decode, strobe edge detect, read mux, op counter, GPIO latch.
// Optional upper-result register at 0x03A8 with GPIO_MULPOP_RESULT_HI_EN.
module gpio_mulpop
    import gpio_mulpop_pkg::*;
#(
    parameter int          OP_W    = 24,
    parameter int          CNT_W   = 16,
    parameter logic [15:0] BASE_A1 = ADDR_A1
) (
    input  logic                clk,
    input  logic                n_reset,
    gpio_mulpop_if.slave        bus,
    input  logic [31:0]         gpio_in,
    input  logic                gpio_latch,
    output logic [31:0]         gpio_out,
    output logic [31:0]         gpio_in_s_insp
);
    logic              srd_q, swr_q;
    logic [OP_W-1:0]   a1_q, a1_d, a2_q, a2_d;
    logic [31:0]       sdata_out_q, sdata_out_d, rd_data_s;
    logic [CNT_W-1:0]  op_count_q, op_count_d;
    logic [31:0]       gpio_in_s_q, gpio_in_s_d;
    logic              rd_edge_s, wr_edge_s, start_s;
    logic              busy_s, done_pulse_s, valid_s, ready_s, done_s;
    logic [31:0]       res_lo_s;
    logic [5:0]        ones_s;
    logic [2:0]        status_s;
    logic              unused_ok_s;
`ifdef GPIO_MULPOP_RESULT_HI_EN
    logic [31:0]       res_hi_s;
`endif

    assign rd_edge_s   = bus.srd & ~srd_q;
    assign wr_edge_s   = bus.swr & ~swr_q;
    assign start_s     = wr_edge_s && (bus.saddress == ADDR_CTRL) && bus.sdata_in[0] && !busy_s;
    assign unused_ok_s = &{1'b0, bus.sdata_in};

    mulpop_core #(.OP_W(OP_W)) u_core (
        .clk        (clk),
        .n_reset    (n_reset),
        .a1         (a1_q),
        .a2         (a2_q),
        .start      (start_s),
        .busy       (busy_s),
        .done_pulse (done_pulse_s),
        .res_lo     (res_lo_s),
`ifdef GPIO_MULPOP_RESULT_HI_EN
        .res_hi     (res_hi_s),
`endif
        .ones       (ones_s),
        .valid      (valid_s),
        .ready      (ready_s),
        .done       (done_s)
    );

    always_comb begin
        status_s             = 3'd0;
        status_s[STAT_VALID] = valid_s;
        status_s[STAT_READY] = ready_s;
        status_s[STAT_DONE]  = done_s;
    end

    // Read mux: write-only and unmapped addresses read as zero
    always_comb begin
        rd_data_s = 32'd0;
        case (bus.saddress)
            ADDR_W:    rd_data_s = res_lo_s;
            ADDR_L:    rd_data_s = {26'd0, ones_s};
            ADDR_CTRL: rd_data_s = {29'd0, status_s};
`ifdef GPIO_MULPOP_RESULT_HI_EN
            ADDR_HI:   rd_data_s = res_hi_s;
`endif
            default:   rd_data_s = 32'd0;
        endcase
    end

    always_comb begin
        a1_d        = (wr_edge_s && bus.saddress == BASE_A1)  ? bus.sdata_in[OP_W-1:0] : a1_q;
        a2_d        = (wr_edge_s && bus.saddress == ADDR_A2)  ? bus.sdata_in[OP_W-1:0] : a2_q;
        sdata_out_d = rd_edge_s    ? rd_data_s                   : sdata_out_q;
        op_count_d  = done_pulse_s ? op_count_q + CNT_W'(1)      : op_count_q;
        gpio_in_s_d = gpio_latch   ? gpio_in                     : gpio_in_s_q;
    end

    // Bus-side registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            srd_q       <= 1'b0;
            swr_q       <= 1'b0;
            a1_q        <= '0;
            a2_q        <= '0;
            sdata_out_q <= 32'd0;
            op_count_q  <= '0;
            gpio_in_s_q <= 32'd0;
        end else begin
            srd_q       <= bus.srd;
            swr_q       <= bus.swr;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            sdata_out_q <= sdata_out_d;
            op_count_q  <= op_count_d;
            gpio_in_s_q <= gpio_in_s_d;
        end
    end

    assign bus.sdata_out  = sdata_out_q;
    assign gpio_out       = 32'(op_count_q);
    assign gpio_in_s_insp = gpio_in_s_q;

endmodule

// File: tb/tb_gpio_mulpop.sv
// Scoreboard bench for gpio_mulpop (OP_W=24, CNT_W=4 so the op counter wraps quickly).
module tb_gpio_mulpop;
    localparam int          OP_W   = 24;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] OPMASK = 32'h00FF_FFFF;
    localparam logic [15:0] A_A1 = 16'h037F, A_A2 = 16'h0388, A_W = 16'h0390;
    localparam logic [15:0] A_L  = 16'h0398, A_CT = 16'h03A0, A_HI = 16'h03A8;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [31:0] gpio_in = 32'd0;
    logic        gpio_latch = 1'b0;
    logic [31:0] gpio_out, gpio_in_s_insp;

    gpio_mulpop_if bus ();

    gpio_mulpop #(.OP_W(OP_W), .CNT_W(CNT_W), .BASE_A1(16'h037F)) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .bus            (bus),
        .gpio_in        (gpio_in),
        .gpio_latch     (gpio_latch),
        .gpio_out       (gpio_out),
        .gpio_in_s_insp (gpio_in_s_insp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic [31:0] l;
        logic [31:0] st;
        logic [31:0] hi;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;

    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.saddress = addr;
        bus.sdata_in = data;
        bus.swr      = 1'b1;
        @(negedge clk);
        bus.swr      = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.saddress = addr;
        bus.srd      = 1'b1;
        @(negedge clk);
        bus.srd      = 1'b0;
        data         = bus.sdata_out;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_expect(input logic [31:0] a1, input logic [31:0] a2);
        exp_t        e;
        logic [63:0] p;
        p    = 64'(a1 & OPMASK) * 64'(a2 & OPMASK);
        e.w  = p[31:0];
        e.l  = 32'($countones(p[31:0]));
`ifdef GPIO_MULPOP_RESULT_HI_EN
        e.hi = p[63:32];
`else
        e.hi = 32'd0;
`endif
        e.st = {29'd0, 1'b1, 1'b1, (p[63:32] == 32'd0)};
        sb.push_back(e);
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    endtask

    task automatic start_op(input logic [31:0] a1, input logic [31:0] a2);
        bus_write(A_A1, a1);
        bus_write(A_A2, a2);
        push_expect(a1, a2);
        bus_write(A_CT, 32'd1);
    endtask

    task automatic wait_done(input string name);
        logic [31:0] st;
        int          polls;
        polls = 0;
        st    = 32'd0;
        while (st[2] !== 1'b1 && polls < 60) begin
            bus_read(A_CT, st);
            polls++;
        end
        checks++;
        if (st[2] !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: got status %h expected done bit set", name, st);
        end
    endtask

    task automatic check_result(input string name);
        exp_t        e;
        logic [31:0] d;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: got empty scoreboard expected entry", name);
        end else begin
            e = sb.pop_front();
            bus_read(A_W, d);  chk({name, "_W"}, d, e.w);
            bus_read(A_L, d);  chk({name, "_L"}, d, e.l);
            bus_read(A_CT, d); chk({name, "_STATUS"}, d, e.st);
            bus_read(A_HI, d); chk({name, "_HI"}, d, e.hi);
            chk({name, "_gpio_out"}, gpio_out, 32'(exp_cnt));
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        chk("rst_gpio_out", gpio_out, 32'd0);
        chk("rst_insp", gpio_in_s_insp, 32'd0);
        chk("rst_sdata_out", bus.sdata_out, 32'd0);
        bus_read(A_CT, d); chk("rst_status", d, 32'd3);
        bus_read(A_W, d);  chk("rst_W", d, 32'd0);
        bus_read(A_L, d);  chk("rst_L", d, 32'd0);
    endtask

    task automatic test_basic_latency();
        start_op(32'd3, 32'd5);
        repeat (OP_W + 1) @(posedge clk);
        #1 chk("lat_before_done", gpio_out, 32'(exp_cnt - 1));
        @(posedge clk);
        #1 chk("lat_at_done", gpio_out, 32'(exp_cnt));
        check_result("basic");
    endtask

    task automatic test_max_operands();
        start_op(32'h00FF_FFFF, 32'h00FF_FFFF);
        wait_done("max");
        check_result("max");
    endtask

    task automatic test_restart_ignored();
        start_op(32'd7, 32'd9);
        repeat (4) @(negedge clk);
        bus_write(A_CT, 32'd1);
        wait_done("restart");
        repeat (OP_W + 8) @(negedge clk);
        check_result("restart");
        chk("restart_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic test_held_strobe();
        bus_write(A_A1, 32'd11);
        bus_write(A_A2, 32'd13);
        push_expect(32'd11, 32'd13);
        @(negedge clk);
        bus.saddress = A_CT;
        bus.sdata_in = 32'd1;
        bus.swr      = 1'b1;
        repeat (2 * OP_W + 10) @(negedge clk);
        bus.swr      = 1'b0;
        check_result("held");
    endtask

    task automatic test_same_cycle_rw();
        bus_write(A_A1, 32'h0012_3456);
        bus_write(A_A2, 32'h0000_0100);
        push_expect(32'h0012_3456, 32'h0000_0100);
        @(negedge clk);
        bus.saddress = A_CT;
        bus.sdata_in = 32'd1;
        bus.srd      = 1'b1;
        bus.swr      = 1'b1;
        @(negedge clk);
        bus.srd      = 1'b0;
        bus.swr      = 1'b0;
        chk("rw_pre_write_status", bus.sdata_out, 32'd7);
        wait_done("rw");
        check_result("rw");
    endtask

    task automatic test_gpio_latch();
        @(negedge clk);
        gpio_in = 32'hA5A5_A5A5;
        repeat (2) @(negedge clk);
        chk("latch_hold_initial", gpio_in_s_insp, 32'd0);
        gpio_latch = 1'b1;
        @(negedge clk);
        gpio_latch = 1'b0;
        gpio_in    = 32'h1234_5678;
        chk("latch_capture", gpio_in_s_insp, 32'hA5A5_A5A5);
        repeat (2) @(negedge clk);
        chk("latch_hold", gpio_in_s_insp, 32'hA5A5_A5A5);
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        bus_read(16'h0400, d); chk("unmapped_0400", d, 32'd0);
        bus_read(A_A1, d);     chk("unmapped_A1", d, 32'd0);
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] d;
        bus_read(A_W, d);
        bus_write(A_A1, 32'h0000_0123);
        bus_write(A_A2, 32'h0000_0456);
        bus_write(A_CT, 32'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        chk("abort_gpio_out", gpio_out, 32'd0);
        chk("abort_sdata_out", bus.sdata_out, 32'd0);
        chk("abort_insp", gpio_in_s_insp, 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        exp_cnt = 0;
        bus_read(A_CT, d); chk("abort_status", d, 32'd3);
        bus_read(A_W, d);  chk("abort_W", d, 32'd0);
        start_op(32'd3, 32'd5);
        wait_done("after_abort");
        check_result("after_abort");
    endtask

    task automatic test_counter_wrap();
        logic [31:0] a1, a2;
        for (int i = 0; i < 15; i++) begin
            a1 = $urandom & OPMASK;
            a2 = $urandom & OPMASK;
            start_op(a1, a2);
            wait_done("wrap");
            check_result("wrap");
        end
        chk("wrap_to_zero", gpio_out, 32'd0);
    endtask

    initial begin
        bus.saddress = 16'd0;
        bus.sdata_in = 32'd0;
        bus.srd      = 1'b0;
        bus.swr      = 1'b0;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_latency();
        test_max_operands();
        test_restart_ignored();
        test_held_strobe();
        test_same_cycle_rw();
        test_gpio_latch();
        test_unmapped();
        test_reset_mid_op();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
